// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, credit-limited imem requests, DEPTH-entry return queue.
// Enqueue-to-line latency 1 cycle; stall holds the head; optional jal follow-through under FETCH_STATIC_JAL_EN.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] line,
  output logic [31:0] line_pc,
  output logic        line_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]   ONE     = CW'(1);
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);
  localparam logic [CW+1:0]   DEPTH_W = (CW+2)'(DEPTH);
  localparam logic [31:0]     NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        q [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count, outstanding, drop_cnt;
  logic [31:0]   fetch_pc, ret_pc;

  logic [CW-1:0] outstanding_n, drop_cnt_n;
  logic [31:0]   fetch_pc_n, ret_pc_n;
  logic [CW+1:0] in_use;
  logic          req_fire, resp_drop, resp_keep, push, pop;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Every slot the queue might need is reserved before a request goes out.
  assign in_use         = {2'b00, count} + {2'b00, outstanding} + {2'b00, drop_cnt};
  assign imem_req_valid = !reset && !redirect_valid && (in_use < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_drop = imem_resp_valid && (drop_cnt != '0);
  assign resp_keep = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;
  assign push      = resp_keep;
  assign pop       = line_valid && !stall && !redirect_valid;

  assign line_valid = !reset && (count != '0);
  assign line       = line_valid ? q[head].instr : NOP;
  assign line_pc    = line_valid ? q[head].pc : 32'h0;

`ifdef FETCH_STATIC_JAL_EN
  logic        jal_hit;
  logic [31:0] jal_imm;
  assign jal_hit = resp_keep && (imem_resp_data[6:0] == 7'b1101111);
  assign jal_imm = {{11{imem_resp_data[31]}}, imem_resp_data[31], imem_resp_data[19:12],
                    imem_resp_data[20], imem_resp_data[30:21], 1'b0};
`endif

  always_comb begin
    fetch_pc_n    = fetch_pc;
    ret_pc_n      = ret_pc;
    outstanding_n = outstanding;
    drop_cnt_n    = drop_cnt;
    if (redirect_valid) begin
      fetch_pc_n    = {redirect_pc[31:2], 2'b00};
      ret_pc_n      = {redirect_pc[31:2], 2'b00};
      // A return landing this cycle retires one of the owed words right away.
      drop_cnt_n    = drop_cnt + outstanding - (imem_resp_valid ? ONE : '0);
      outstanding_n = '0;
    end else begin
      if (req_fire)  fetch_pc_n = fetch_pc + 32'd4;
      if (resp_drop) drop_cnt_n = drop_cnt - ONE;
      if (resp_keep) ret_pc_n   = ret_pc + 32'd4;
      outstanding_n = outstanding + (req_fire ? ONE : '0) - (resp_keep ? ONE : '0);
`ifdef FETCH_STATIC_JAL_EN
      // Requests behind a jal (including one accepted now) are on the wrong path.
      if (jal_hit) begin
        fetch_pc_n    = ret_pc + jal_imm;
        ret_pc_n      = ret_pc + jal_imm;
        drop_cnt_n    = drop_cnt + outstanding_n;
        outstanding_n = '0;
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      ret_pc      <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      fetch_pc    <= fetch_pc_n;
      ret_pc      <= ret_pc_n;
      outstanding <= outstanding_n;
      drop_cnt    <= drop_cnt_n;
      if (redirect_valid) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PTR_ONE;
        if (pop)  head <= head + PTR_ONE;
        count <= count + (push ? ONE : '0) - (pop ? ONE : '0);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) q[tail] <= '{pc: ret_pc, instr: imem_resp_data};
  end

  // A return is only legal when someone is waiting for it.
  a_resp_expected: assert property (@(posedge clock) disable iff (reset)
    imem_resp_valid |-> (outstanding != '0 || drop_cnt != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit with an in-order, pausable instruction memory model.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] line;
  logic [31:0] line_pc;
  logic        line_valid;

  always #5 clock = ~clock;

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .line(line), .line_pc(line_pc), .line_valid(line_valid)
  );

  typedef struct {
    logic        rst, stl, rdy, pause, redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_lv;
    logic [31:0] e_pc;
  } vec_t;

  logic [31:0] pend [$];
  vec_t        tbl [$];
  int          n_chk  = 0;
  int          n_pass = 0;
  bit          jal_mode = 1'b0;

  function automatic vec_t mk(input logic rst, input logic stl, input logic rdy, input logic pause,
                              input logic redir, input logic [31:0] rpc, input logic e_req,
                              input logic [31:0] e_addr, input logic e_lv, input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rdy = rdy; v.pause = pause; v.redir = redir; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_lv = e_lv; v.e_pc = e_pc;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (jal_mode && a == 32'h8) return 32'h0400_006F;  // jal x0, +0x40
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
  endtask

  task automatic apply(input vec_t v, input int row);
    logic        hs, rv;
    logic [31:0] ha;
    reset          = v.rst;
    stall          = v.stl;
    imem_req_ready = v.rdy;
    redirect_valid = v.redir;
    redirect_pc    = v.rpc;
    if (pend.size() != 0) begin
      imem_resp_valid = !v.pause;
      imem_resp_data  = mem_word(pend[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    #1;
    check("req_valid", row, 32'(imem_req_valid), 32'(v.e_req));
    if (v.e_req) check("req_addr", row, imem_req_addr, v.e_addr);
    check("line_valid", row, 32'(line_valid), 32'(v.e_lv));
    check("line_pc", row, line_pc, v.e_lv ? v.e_pc : 32'h0);
    check("line", row, line, v.e_lv ? mem_word(v.e_pc) : 32'h0000_0013);
    hs = imem_req_valid && imem_req_ready;
    ha = imem_req_addr;
    rv = imem_resp_valid;
    @(posedge clock);
    #1;
    if (v.rst) pend.delete();
    else begin
      if (rv) void'(pend.pop_front());
      if (hs) pend.push_back(ha);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; imem_req_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = 32'h0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    @(posedge clock);
    #1;

    //          rst stl rdy pau red rpc           req addr          lv pc
    tbl.push_back(mk(1, 0, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,   1, 32'h4,   0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,   1, 32'h8,   1, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,   1, 32'hC,   1, 32'h4));
    tbl.push_back(mk(0, 1, 1, 0, 0, 32'h0,   1, 32'h10,  1, 32'h8));
    tbl.push_back(mk(0, 1, 1, 0, 0, 32'h0,   1, 32'h14,  1, 32'h8));
    tbl.push_back(mk(0, 1, 1, 0, 0, 32'h0,   0, 32'h18,  1, 32'h8));
    tbl.push_back(mk(0, 1, 1, 0, 0, 32'h0,   0, 32'h18,  1, 32'h8));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,   0, 32'h18,  1, 32'h8));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,   1, 32'h18,  1, 32'hC));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,   1, 32'h1C,  1, 32'h10));
    tbl.push_back(mk(0, 0, 1, 1, 0, 32'h0,   1, 32'h20,  1, 32'h14));
    tbl.push_back(mk(0, 0, 1, 1, 1, 32'h103, 0, 32'h24,  1, 32'h18));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,   1, 32'h104, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,   1, 32'h108, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,   1, 32'h10C, 1, 32'h100));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h200, 0, 32'h110, 1, 32'h104));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,   1, 32'h200, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,   1, 32'h204, 0, 32'h0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,   1, 32'h4,   0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,   1, 32'h8,   1, 32'h0));
    foreach (tbl[i]) apply(tbl[i], i);

    // Back-to-back redirects: the second one wins, and its low address bits are cleared.
    apply(mk(0, 0, 1, 0, 1, 32'h300, 0, 32'h0,   1, 32'h4),   100);
    apply(mk(0, 0, 1, 0, 1, 32'h407, 0, 32'h0,   0, 32'h0),   101);
    apply(mk(0, 0, 1, 0, 0, 32'h0,   1, 32'h404, 0, 32'h0),   102);
    apply(mk(0, 0, 1, 0, 0, 32'h0,   1, 32'h408, 0, 32'h0),   103);
    apply(mk(0, 0, 1, 0, 0, 32'h0,   1, 32'h40C, 1, 32'h404), 104);

`ifdef FETCH_STATIC_JAL_EN
    // jal at 0x8 jumps to 0x48; the word fetched from 0xC is thrown away.
    jal_mode = 1'b1;
    apply(mk(1, 0, 1, 0, 0, 32'h0, 0, 32'h0,  0, 32'h0),  200);
    apply(mk(0, 0, 1, 0, 0, 32'h0, 1, 32'h0,  0, 32'h0),  201);
    apply(mk(0, 0, 1, 0, 0, 32'h0, 1, 32'h4,  0, 32'h0),  202);
    apply(mk(0, 0, 1, 0, 0, 32'h0, 1, 32'h8,  1, 32'h0),  203);
    apply(mk(0, 0, 1, 0, 0, 32'h0, 1, 32'hC,  1, 32'h4),  204);
    apply(mk(0, 0, 1, 0, 0, 32'h0, 1, 32'h48, 1, 32'h8),  205);
    apply(mk(0, 0, 1, 0, 0, 32'h0, 1, 32'h4C, 0, 32'h0),  206);
    apply(mk(0, 0, 1, 0, 0, 32'h0, 1, 32'h50, 1, 32'h48), 207);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
